// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with start-glitch rejection, sticky framing/overrun flags
// and a first-word-fall-through receive FIFO drained by firmware.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 347,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                           clock,
   input  logic                           resetb,
   input  logic                           rx,
   input  logic                           rd_en,
   output logic [7:0]                     rd_data,
   output logic                           rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           frame_err,
   output logic                           overrun,
   input  logic                           clr_err,
   output logic                           busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   logic          r_sync1, r_rx_s;
   logic [2:0]    r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shreg;
   logic          r_busy, r_frame_err, r_overrun;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;

   logic w_tick, w_stop_ok, w_stop_bad, w_full, w_pop, w_push;

   assign w_tick     = (r_bit_cnt == '0);
   assign w_stop_ok  = (r_state == S_STOP) && w_tick && r_rx_s;
   assign w_stop_bad = (r_state == S_STOP) && w_tick && !r_rx_s;
   assign w_full     = (r_count == FULL_CNT);
   assign w_pop      = rd_en && (r_count != '0);
   // A pop in the stop-sample cycle frees the slot the new byte needs.
   assign w_push     = w_stop_ok && (!w_full || w_pop);

   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_busy <= (r_state != S_IDLE);
         case (r_state)
            S_IDLE: if (!r_rx_s) begin
               r_bit_cnt <= HALF_LOAD;
               r_state   <= S_START;
            end
            S_START: if (w_tick) begin
               if (!r_rx_s) begin
                  r_bit_cnt <= BIT_LOAD;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_state <= S_IDLE;
               end
            end else begin
               r_bit_cnt <= r_bit_cnt - CW'(1);
            end
            S_DATA: if (w_tick) begin
               r_shreg[r_bit_idx] <= r_rx_s;
               r_bit_cnt          <= BIT_LOAD;
               r_bit_idx          <= r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) r_state <= S_STOP;
            end else begin
               r_bit_cnt <= r_bit_cnt - CW'(1);
            end
            S_STOP: if (w_tick) begin
               r_state <= r_rx_s ? S_IDLE : S_WAIT;
            end else begin
               r_bit_cnt <= r_bit_cnt - CW'(1);
            end
            S_WAIT:  if (r_rx_s) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= r_shreg;
   end

   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Clear wins over a same-cycle set.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (clr_err)         r_frame_err <= 1'b0;
         else if (w_stop_bad) r_frame_err <= 1'b1;
         if (clr_err)                                r_overrun <= 1'b0;
         else if (w_stop_ok && w_full && !w_pop)     r_overrun <= 1'b1;
      end
   end

   assign rd_data    = r_mem[r_rd_ptr];
   assign rx_valid   = (r_count != '0);
   assign fifo_count = r_count;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven on rx, results checked
// through the FIFO read port and status outputs.
module tb_uart_rx_fifo;

   localparam int CPB  = 32;
   localparam int HALF = CPB/2;

   logic       clock = 1'b0;
   logic       resetb, rx, rd_en, clr_err;
   logic [7:0] rd_data;
   logic       rx_valid, frame_err, overrun, busy;
   logic [3:0] fifo_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clock(clock), .resetb(resetb), .rx(rx), .rd_en(rd_en),
      .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
      .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Frame starts at the current negedge; pop_at_stop raises rd_en exactly
   // for the clock edge on which the receiver samples the stop bit.
   task automatic send(input logic [7:0] d, input logic stop,
                       input bit pop_at_stop, input logic rx_after);
      rx = 1'b0;
      idle(CPB);
      for (int b = 0; b < 8; b++) begin
         rx = d[b];
         idle(CPB);
      end
      rx = stop;
      for (int i = 0; i < CPB; i++) begin
         rd_en = pop_at_stop && (i == HALF + 2);
         @(negedge clock);
      end
      rd_en = 1'b0;
      rx    = rx_after;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk({tag, ".valid"}, 32'(rx_valid), 32'd1);
      chk({tag, ".data"}, 32'(rd_data), 32'(exp));
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
   endtask

   logic [7:0] seq10 [10] = '{8'h0F, 8'h0A, 8'h36, 8'h19, 8'hAA,
                              8'h45, 8'h4D, 8'h02, 8'h2B, 8'h16};

   initial begin
      resetb = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      idle(4);
      resetb = 1'b1;
      idle(2);
      chk("rst.valid", 32'(rx_valid), 32'd0);
      chk("rst.count", 32'(fifo_count), 32'd0);
      chk("rst.ferr", 32'(frame_err), 32'd0);
      chk("rst.ovr", 32'(overrun), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);

      // single byte
      send(8'h0F, 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("one.count", 32'(fifo_count), 32'd1);
      chk("one.busy", 32'(busy), 32'd0);
      pop_chk("one", 8'h0F);
      chk("one.empty", 32'(rx_valid), 32'd0);
      chk("one.count0", 32'(fifo_count), 32'd0);

      // ten bytes, drained one by one
      for (int k = 0; k < 10; k++) begin
         send(seq10[k], 1'b1, 1'b0, 1'b1);
         idle(2*CPB);
         chk("seq.count", 32'(fifo_count), 32'd1);
         pop_chk("seq", seq10[k]);
      end
      chk("seq.ferr", 32'(frame_err), 32'd0);
      chk("seq.ovr", 32'(overrun), 32'd0);

      // overrun: nine back-to-back frames, no reads
      for (int k = 0; k < 9; k++) send(8'h30 + 8'(k), 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("ovr.count", 32'(fifo_count), 32'd8);
      chk("ovr.flag", 32'(overrun), 32'd1);
      chk("ovr.ferr", 32'(frame_err), 32'd0);
      for (int k = 0; k < 8; k++) pop_chk("ovr.drain", 8'h30 + 8'(k));
      chk("ovr.empty", 32'(rx_valid), 32'd0);
      clr_err = 1'b1;
      @(negedge clock);
      clr_err = 1'b0;
      chk("ovr.clr", 32'(overrun), 32'd0);

      // framing error followed by a long break
      send(8'h55, 1'b0, 1'b0, 1'b0);
      idle(20*CPB);
      chk("fe.flag", 32'(frame_err), 32'd1);
      chk("fe.count", 32'(fifo_count), 32'd0);
      chk("fe.busy", 32'(busy), 32'd1);
      rx = 1'b1;
      idle(5);
      chk("fe.busy0", 32'(busy), 32'd0);
      clr_err = 1'b1;
      @(negedge clock);
      clr_err = 1'b0;
      chk("fe.clr", 32'(frame_err), 32'd0);
      send(8'h3C, 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("fe.next.count", 32'(fifo_count), 32'd1);
      pop_chk("fe.next", 8'h3C);

      // start-bit glitch shorter than half a bit
      rx = 1'b0;
      idle(CPB/4);
      rx = 1'b1;
      idle(2*CPB);
      chk("gl.count", 32'(fifo_count), 32'd0);
      chk("gl.ferr", 32'(frame_err), 32'd0);
      chk("gl.ovr", 32'(overrun), 32'd0);
      chk("gl.busy", 32'(busy), 32'd0);

      // reset four bits into a frame
      rx = 1'b0;
      idle(CPB);
      rx = 1'b1;
      idle(3*CPB);
      resetb = 1'b0;
      idle(2);
      resetb = 1'b1;
      idle(2*CPB);
      chk("rstmid.count", 32'(fifo_count), 32'd0);
      chk("rstmid.busy", 32'(busy), 32'd0);
      send(8'hA5, 1'b1, 1'b0, 1'b1);
      idle(4);
      pop_chk("rstmid.next", 8'hA5);

      // full FIFO, pop on the stop-sample edge of the next frame
      for (int k = 0; k < 8; k++) send(8'h10 + 8'(k), 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("pp.full", 32'(fifo_count), 32'd8);
      send(8'h99, 1'b1, 1'b1, 1'b1);
      idle(4);
      chk("pp.ovr", 32'(overrun), 32'd0);
      chk("pp.count", 32'(fifo_count), 32'd8);
      for (int k = 1; k < 8; k++) pop_chk("pp.drain", 8'h10 + 8'(k));
      pop_chk("pp.last", 8'h99);
      chk("pp.empty", 32'(fifo_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

User-project UART receiver that consumes the serial stream driven onto `mprj_io[5]` by the board-side UART. Deserializes 8N1 frames, rejects start-bit glitches, flags framing and overrun errors, and buffers received bytes in a small first-word-fall-through FIFO. Firmware drains the FIFO through the Wishbone slave.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 347: clock cycles per bit. 40 MHz / 115200 baud. Minimum legal value is 8.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of two, ≥2.

Ports:
- `clock`  in  1: single clock. All logic is on its rising edge.
- `resetb`  in  1: synchronous, active-low reset.
- `rx`  in  1: serial input from `mprj_io[5]`. Asynchronous to `clock`; idles high.
- `rd_en`  in  1: pop request. Ignored when `rx_valid`=0.
- `rd_data`  out  8: head-of-FIFO byte. Valid while `rx_valid`=1.
- `rx_valid`  out  1: FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of entries held.
- `frame_err`  out  1: sticky; a frame ended with stop bit = 0.
- `overrun`  out  1: sticky; a good frame arrived while the FIFO was full.
- `clr_err`  in  1: clears `frame_err` and `overrun`.
- `busy`  out  1: receiver is in any state other than IDLE.

## Operation

- **Input synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. The first flop resets to 1. All decisions use `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rx_s`=0, load `bit_cnt` with `CLKS_PER_BIT/2 - 1` (integer divide) and go to START.
- **START:** `bit_cnt` counts down. At 0, sample `rx_s`.
  - If 0: reload `CLKS_PER_BIT-1`, clear `bit_idx`, go to DATA.
  - If 1: treat as a glitch and return to IDLE. No flag is set.
- **DATA:** at each countdown expiry, shift `rx_s` into `shreg[bit_idx]` (LSB first), then reload.
  - After bit 7 is sampled, go to STOP.
- **STOP:** at countdown expiry, sample `rx_s`.
  - If 1 and FIFO not full: push `shreg`.
  - If 1 and FIFO full: drop the byte and set `overrun`. Exception: if `rd_en` pops in the same cycle, the push is accepted.
  - Either way, go to IDLE.
  - If 0: drop the byte, set `frame_err`, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being seen as repeated frames.
- **FIFO:** circular buffer with `FIFO_DEPTH` entries and read/write pointers that wrap modulo `FIFO_DEPTH`. A separate count register drives full/empty; pointer comparison is not used for this.
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full and when count=1. It is not legal when empty, because no pop occurs then.
- **Read side:** `rd_data` = `mem[rd_ptr]`, combinational from registered storage. `rd_en` with `rx_valid`=0 has no effect.
- **Error flags:** `clr_err` has priority over a same-cycle set, so the flag reads 0 on the next cycle.
- **Reset:** a reset in the middle of a frame aborts it. No partial byte is pushed. After reset the receiver waits for the next falling edge of `rx_s`.
- **Reset values:** FSM=IDLE, pointers=0, count=0, `rx_valid`=0, `fifo_count`=0, `rd_data`=`mem[0]` (contents don't-care), `frame_err`=0, `overrun`=0, `busy`=0, synchronizer flops=1.

## Timing

- **Synchronizer latency:** 2 cycles from `rx` to `rx_s`.
- **Sample points:** the start bit is sampled `CLKS_PER_BIT/2` cycles after `rx_s` falls. Data bit n is sampled `(n+1)*CLKS_PER_BIT` cycles after the start sample. The stop bit is sampled `9*CLKS_PER_BIT` cycles after the start sample.
- **Push timing:** the push occurs on the clock edge of the stop sample. `rx_valid` and `fifo_count` update on the same edge, so they are visible in the cycle after the stop sample.
- **Pop timing:** a pop is registered on the edge where `rd_en`=1. `rd_data`, `rx_valid` and `fifo_count` reflect the pop in the following cycle.
- **Error flag timing:** `frame_err` and `overrun` assert in the cycle after the stop sample.
- **`busy`:** registered from the FSM state. It rises the cycle after IDLE→START and falls the cycle after returning to IDLE.
- **Back-to-back frames:** the receiver returns to IDLE at mid-stop-bit. A new start edge half a bit later is caught. A sender clock up to ±2% off is tolerated.

## Test plan

- **Single byte:** after reset, send 8N1 frame 0x0F at 347 clocks/bit → `rx_valid`=1, `rd_data`=0x0F, `fifo_count`=1. Pulse `rd_en` → `rx_valid`=0, `fifo_count`=0.
- **Ten-byte sequence:** send 0x0F, 0x0A, 0x36, 0x19, 0xAA, 0x45, 0x4D, 0x02, 0x2B, 0x16 with a 105 µs frame spacing, draining after each → the bytes are read back in order, and no error flag is set.
- **Overrun:** send 9 frames back-to-back without reading → `fifo_count`=8 and `overrun`=1. Draining returns the first 8 bytes; the 9th is lost. Pulse `clr_err` → `overrun`=0.
- **Framing error:** send 0x55 with the stop bit driven 0, hold `rx` low for 20 bit-times, then release → `frame_err`=1, `fifo_count`=0, `busy`=1 until `rx` returns high. The next valid frame 0x3C is received correctly.
- **Glitch rejection:** drive a 100-cycle low pulse on `rx` → returns to IDLE with no push and no flags. Also issue reset 4 bits into a frame → no push; the next frame 0xA5 is received correctly.
- **Simultaneous push and pop when full:** fill the FIFO to 8, then assert `rd_en` on the stop-sample cycle of the next frame → `overrun`=0, `fifo_count` stays 8, and the new byte appears as the last entry.
